rr_arbiter4: RTL



---
 rtl/rr_arbiter4_if.sv | 34 +++
 rtl/rr_arbiter4.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter4_if.sv
// rtl/rr_arbiter4_if.sv - request/grant bundle between requesters and the round-robin arbiter
//
// Signals:
//   req       [3:0] request lines, bit i is requester i (level-sensitive)
//   done            current owner releases its grant
//   gnt       [3:0] registered one-hot grant (all-zero when idle)
//   gnt_valid       high exactly when gnt is non-zero
//   timeout         one-cycle pulse when a grant is revoked by the hold limit
// Modports:
//   master : requester side (drives req/done, observes grant outputs)
//   slave  : arbiter side (observes req/done, drives grant outputs)
interface rr_arbiter4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with hold-time preemption
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles before preemption when another
//             request is pending (legal range 2..255)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter4_if.slave: req/done in, gnt/gnt_valid/timeout out
// All outputs come straight from flops; there is no combinational req->gnt path.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_arbiter4_if.slave     bus
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    owner_q, owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;

  // Rotating priority search: first set request starting at ptr, wrapping mod 4.
  logic [1:0] scan_idx;
  logic [1:0] pick;
  logic       found;

  always_comb begin
    scan_idx = ptr_q;
    pick     = ptr_q;
    found    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!found && bus.req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  // Release conditions evaluated in GRANT, in priority order.
  logic owner_req;
  logic others_pending;
  logic hold_expired;

  always_comb begin
    owner_req      = bus.req[owner_q];
    others_pending = |(bus.req & ~(4'b0001 << owner_q));
    hold_expired   = (hold_q == HOLD_LAST) && others_pending;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d     = pick;
          gnt_d       = 4'b0001 << pick;
          gnt_valid_d = 1'b1;
          hold_d      = '0;
          state_d     = GRANT;
        end else begin
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
        end
      end

      GRANT: begin
        if (bus.done || !owner_req || hold_expired) begin
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
          ptr_d       = owner_q + 2'd1;
          state_d     = IDLE;
          // Only a pure hold-limit release counts as a timeout; done or a
          // dropped request take precedence and make it a normal release.
          timeout_d   = !bus.done && owner_req;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = 4'b0000;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      owner_q     <= 2'd0;
      hold_q      <= '0;
      gnt_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule
